// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and the iteration count of the sequential datapath.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned MULDIV_ITER = 32;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Sequential datapath: one shift-add (multiply) or restoring (divide) step per
// cycle on a double-width accumulator, with operand magnitude and sign fix-up.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            op_div,
  input  logic            op_signed,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_p;
  logic              neg_r;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign a_mag = (op_signed && src_a[XLEN-1]) ? -src_a : src_a;
  assign b_mag = (op_signed && src_b[XLEN-1]) ? -src_b : src_b;
  assign last  = (cnt == CW'(ITER - 1));

  always_comb begin
    mul_addend = acc[0] ? opnd : '0;
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc[XLEN-1:1]};
    // Shifted partial remainder can reach XLEN+1 bits; the trial's MSB is the borrow.
    div_trial  = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    div_next   = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      acc    <= {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
      opnd   <= op_div ? b_mag : a_mag;
      cnt    <= '0;
      is_div <= op_div;
      neg_p  <= op_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
      neg_r  <= op_signed & src_a[XLEN-1];
    end else if (step) begin
      acc <= is_div ? div_next : mul_next;
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    prod   = neg_p ? -acc : acc;
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      res_lo = neg_p ? -quo : quo;
      res_hi = neg_r ? -rem : rem;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, pipeline stall generation and the
// architectural HI/LO registers around the iterative datapath.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = MULDIV_ITER
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic [XLEN-1:0] ex_src_a,
  input  logic [XLEN-1:0] ex_src_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t          state;
  state_t          state_n;
  logic            muldiv_req;
  logic            start;
  logic            calc_step;
  logic            core_last;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  assign muldiv_req = ex_valid & is_muldiv(ex_op);
  assign start      = muldiv_req & ~flush & (state == ST_IDLE);
  assign calc_step  = (state == ST_CALC) & ~flush;
  // The instruction leaves EX in the DONE cycle, so it must not be held there.
  assign stall      = muldiv_req & (state != ST_DONE) & ~flush;

  muldiv_iter_core #(
    .XLEN (XLEN),
    .ITER (ITER)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .step      (calc_step),
    .op_div    (is_div_op(ex_op)),
    .op_signed (is_signed_op(ex_op)),
    .src_a     (ex_src_a),
    .src_b     (ex_src_b),
    .last      (core_last),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_CALC;
      ST_CALC: if (core_last) state_n = ST_FIX;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (state == ST_FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == ST_IDLE && ex_valid) begin
        if (ex_op == OP_MTHI) hi <= ex_src_a;
        if (ex_op == OP_MTLO) lo <= ex_src_a;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected HI/LO per
// operation, plus timing, MTHI/MTLO, flush and reset scenarios.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_src_a;
  logic [31:0] ex_src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] sh_hi;
  logic [31:0] sh_lo;

  ex_muldiv_unit #(
    .XLEN (32),
    .ITER (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex_op    (ex_op),
    .ex_src_a (ex_src_a),
    .ex_src_b (ex_src_b),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000 time units");
    $fatal(1);
  end

  // Reference: {HI, LO} as defined for each op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    q   = '0;
    r   = '0;
    res = '0;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'h0, a} * {32'h0, b};
      OP_DIVU: begin
        if (b == 32'h0) begin q = 32'hFFFFFFFF; r = a; end
        else begin q = a / b; r = a % b; end
        res = {r, q};
      end
      OP_DIV: begin
        if (b == 32'h0) begin q = a[31] ? 32'd1 : 32'hFFFFFFFF; r = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = 32'h80000000; r = 32'h0; end
        else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
        res = {r, q};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Drives one muldiv op (aligned just after a rising edge), holds it until the
  // DONE cycle, then retires it. Returns observed timing and HI/LO at DONE.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int done_cyc, output int dones,
                        output logic [63:0] obs);
    stalls   = 0;
    done_cyc = -1;
    dones    = 0;
    obs      = '0;
    ex_valid = 1'b1;
    ex_op    = op;
    ex_src_a = a;
    ex_src_b = b;
    exp_q.push_back(model(op, a, b));
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          obs = {hi, lo};
        end
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
  endtask

  task automatic write_hilo(input logic [2:0] op, input logic [31:0] d);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_src_a = d;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    if (op == OP_MTHI) sh_hi = d;
    else sh_lo = d;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h required %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h required %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b required 0", stall); end
    ex_valid = 1'b1;
    ex_op    = OP_DIV;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %b required 1", stall); end
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    @(posedge clk); #1;
    reset = 1'b0;
    sh_hi = '0;
    sh_lo = '0;
  endtask

  task automatic test_arith;
    logic [2:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    int stalls, dcyc, dones;
    logic [63:0] obs, exp;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    as  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFF9};
    bs  = '{32'h3, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], stalls, dcyc, dones, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL arith%0d_hilo: got %h required %h", i, obs, exp); end
      n_checks++; if (stalls !== 34) begin n_fail++; $display("FAIL arith%0d_stall_cycles: got %0d required 34", i, stalls); end
      n_checks++; if (dcyc !== 34) begin n_fail++; $display("FAIL arith%0d_done_cycle: got %0d required 34", i, dcyc); end
      sh_hi = exp[63:32];
      sh_lo = exp[31:0];
    end
  endtask

  task automatic test_mthi_mtlo;
    int stalls, dcyc, dones;
    logic [63:0] obs, exp;
    ex_valid = 1'b1;
    ex_op    = OP_MTHI;
    ex_src_a = 32'h12345678;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b required 0", stall); end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    sh_hi    = 32'h12345678;
    @(negedge clk);
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h required %h", hi, 32'h12345678); end
    n_checks++; if (lo !== sh_lo) begin n_fail++; $display("FAIL mthi_lo_kept: got %h required %h", lo, sh_lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b required 0", busy); end
    @(posedge clk); #1;
    write_hilo(OP_MTLO, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++; if (lo !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mtlo_lo: got %h required %h", lo, 32'hCAFEF00D); end
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h required %h", hi, 32'h12345678); end
    @(posedge clk); #1;
    run_op(OP_MULT, 32'd2, 32'd3, stalls, dcyc, dones, obs);
    exp = exp_q.pop_front();
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL mult_after_mthi: got %h required %h", obs, exp); end
    sh_hi = exp[63:32];
    sh_lo = exp[31:0];
  endtask

  task automatic test_flush;
    int n_done;
    write_hilo(OP_MTHI, 32'hAAAAAAAA);
    write_hilo(OP_MTLO, 32'h55555555);
    ex_valid = 1'b1;
    ex_op    = OP_DIV;
    ex_src_a = 32'd100;
    ex_src_b = 32'd7;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_masked: got %b required 0", stall); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b required 1", busy); end
    @(posedge clk); #1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b required 0", busy); end
    n_checks++; if (hi !== sh_hi) begin n_fail++; $display("FAIL flush_hi_kept: got %h required %h", hi, sh_hi); end
    n_checks++; if (lo !== sh_lo) begin n_fail++; $display("FAIL flush_lo_kept: got %h required %h", lo, sh_lo); end
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d done pulses required 0", n_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ex_valid = 1'b1;
    ex_op    = OP_MULT;
    ex_src_a = 32'd5;
    ex_src_b = 32'd7;
    repeat (15) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b required 1", busy); end
    #2;
    reset    = 1'b1;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    #1;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi: got %h required %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo: got %h required %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_done_stall: got %b%b required 00", done, stall); end
    @(posedge clk); #1;
    reset = 1'b0;
    sh_hi = '0;
    sh_lo = '0;
  endtask

  task automatic test_hold_valid;
    int stalls, dcyc, dones, extra, busy_seen;
    logic [63:0] obs, exp;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, stalls, dcyc, dones, obs);
    exp = exp_q.pop_front();
    n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL hold_hilo: got %h required %h", obs, exp); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL hold_done_pulses: got %0d required 1", dones); end
    extra = 0;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) busy_seen++;
    end
    n_checks++; if (extra !== 0 || busy_seen !== 0) begin n_fail++; $display("FAIL hold_no_restart: got %0d done %0d busy cycles required 0 0", extra, busy_seen); end
    @(posedge clk); #1;
    sh_hi = exp[63:32];
    sh_lo = exp[31:0];
  endtask

  task automatic test_back_to_back;
    int stalls, dcyc, dones;
    logic [63:0] obs, exp;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i == 3) b = 32'h0;
      if (i == 5) b = 32'hFFFFFFFF;
      if (i == 7) a = 32'h80000000;
      run_op(op, a, b, stalls, dcyc, dones, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL b2b%0d_hilo op=%0d a=%h b=%h: got %h required %h", i, op, a, b, obs, exp); end
      n_checks++; if (dcyc !== 34 || stalls !== 34) begin n_fail++; $display("FAIL b2b%0d_timing: got done %0d stall %0d required 34 34", i, dcyc, stalls); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ex_valid = 1'b0;
    ex_op    = OP_NOP;
    ex_src_a = '0;
    ex_src_b = '0;
    flush    = 1'b0;
    sh_hi    = '0;
    sh_lo    = '0;
    test_reset;
    test_arith;
    test_mthi_mtlo;
    test_flush;
    test_reset_mid;
    test_hold_valid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
